adpcm_main_mac_pipe: RTL and testbench

- Parametrised, pipelined signed multiply / multiply-accumulate unit for the ADPCM datapath. It is the successor to the single-cycle combinational 16x16 signed multiplier.
- Adds configurable pipeline depth, a valid/ready handshake with backpressure, and an accumulate mode with end-of-group emission.
- Adds Q-format rounding and output saturation with a flag.
- Used by the predictor/filter loops, which need dot products of coefficient and history samples.

---
 rtl/adpcm_main_mac_pipe.sv | 153 +++++++++++++++
 tb/tb_adpcm_main_mac_pipe.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adpcm_main_mac_pipe.sv
// Pipelined signed multiply / multiply-accumulate for the ADPCM predictor loops.
// Global-enable pipeline with valid/ready, Q-format round-half-up and output clamping.
module adpcm_main_mac_pipe #(
  parameter int DIN0_WIDTH = 16,
  parameter int DIN1_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int DOUT_WIDTH = 32,
  parameter int NUM_STAGE  = 3,
  parameter int SHIFT      = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  mode,
  input  logic                  acc_clr,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_sat
);

  localparam int PW  = DIN0_WIDTH + DIN1_WIDTH;
  localparam int TW  = ACC_WIDTH + 1;
  localparam int CW  = ((TW > DOUT_WIDTH) ? TW : DOUT_WIDTH) + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [TW-1:0] RND     = TW'(1) << RSH;
  localparam logic signed [CW-1:0] SAT_MAX = {{(CW-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [CW-1:0] SAT_MIN = {{(CW-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  logic                         en;
  logic signed [PW-1:0]         prod;
  logic                         e_valid, e_mode, e_clr, e_last;
  logic signed [PW-1:0]         e_p;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, p_ext, sum, r;
  logic signed [TW-1:0]         r_ext, t;
  logic signed [CW-1:0]         t_ext;
  logic                         emit;
  logic [DOUT_WIDTH-1:0]        fmt_val;
  logic                         fmt_sat;
  logic                         out_valid_q, out_valid_d;
  logic [DOUT_WIDTH-1:0]        dout_q, dout_d;
  logic                         dout_sat_q, dout_sat_d;

  // A single enable stalls every stage at once, so nothing is lost or duplicated.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign prod     = PW'($signed(din0)) * PW'($signed(din1));

  generate
    if (NUM_STAGE == 1) begin : g_direct
      assign e_valid = in_valid;
      assign e_p     = prod;
      assign e_mode  = mode;
      assign e_clr   = acc_clr;
      assign e_last  = in_last;
    end else begin : g_pipe
      localparam int D = NUM_STAGE - 1;
      logic [D-1:0]         v_q, m_q, c_q, l_q;
      logic signed [PW-1:0] p_q [D];

      always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
          v_q <= '0;
          m_q <= '0;
          c_q <= '0;
          l_q <= '0;
          for (int unsigned i = 0; i < D; i++) p_q[i] <= '0;
        end else if (en) begin
          v_q[0] <= in_valid;
          m_q[0] <= mode;
          c_q[0] <= acc_clr;
          l_q[0] <= in_last;
          p_q[0] <= prod;
          for (int unsigned i = 1; i < D; i++) begin
            v_q[i] <= v_q[i-1];
            m_q[i] <= m_q[i-1];
            c_q[i] <= c_q[i-1];
            l_q[i] <= l_q[i-1];
            p_q[i] <= p_q[i-1];
          end
        end
      end

      assign e_valid = v_q[D-1];
      assign e_p     = p_q[D-1];
      assign e_mode  = m_q[D-1];
      assign e_clr   = c_q[D-1];
      assign e_last  = l_q[D-1];
    end
  endgenerate

  always_comb begin
    p_ext = ACC_WIDTH'(e_p);
    sum   = (e_clr ? '0 : acc_q) + p_ext;
    r     = e_mode ? sum : p_ext;
    emit  = e_valid && (!e_mode || e_last);
    acc_d = acc_q;
    if (en && e_valid && e_mode) acc_d = e_last ? '0 : sum;
  end

  always_comb begin
    r_ext = TW'(r);
    if (SHIFT > 0) t = (r_ext + RND) >>> SHIFT;
    else           t = r_ext;
    t_ext = CW'(t);
    if (t_ext > SAT_MAX) begin
      fmt_val = SAT_MAX[DOUT_WIDTH-1:0];
      fmt_sat = 1'b1;
    end else if (t_ext < SAT_MIN) begin
      fmt_val = SAT_MIN[DOUT_WIDTH-1:0];
      fmt_sat = 1'b1;
    end else begin
      fmt_val = t_ext[DOUT_WIDTH-1:0];
      fmt_sat = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    dout_sat_d  = dout_sat_q;
    if (en) begin
      out_valid_d = emit;
      if (emit) begin
        dout_d     = fmt_val;
        dout_sat_d = fmt_sat;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      dout_sat_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      dout_sat_q  <= dout_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_sat  = dout_sat_q;

endmodule

// File: tb/tb_adpcm_main_mac_pipe.sv
// Bench for adpcm_main_mac_pipe: a 32-bit-output and a 16-bit-output instance driven in lockstep,
// checked against constants and an arithmetic model of the multiply/accumulate/round/clamp rules.
module tb_adpcm_main_mac_pipe;

  logic        ap_clk, ap_rst_n, in_valid, mode, acc_clr, in_last, out_ready;
  logic [15:0] din0, din1;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, sat0, sat1;
  logic [31:0] dout0;
  logic [15:0] dout1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct { logic [31:0] d32; logic s32; logic [15:0] d16; logic s16; int cyc; } obs_t;
  typedef struct { logic [31:0] d32; logic s32; logic [15:0] d16; logic s16; } exp_t;
  obs_t   obs[$];
  exp_t   exp_q[$];
  longint m_acc = 0;

  adpcm_main_mac_pipe u0 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .din0(din0), .din1(din1), .mode(mode), .acc_clr(acc_clr), .in_last(in_last),
    .out_valid(out_valid0), .out_ready(out_ready), .dout(dout0), .dout_sat(sat0));

  adpcm_main_mac_pipe #(.DOUT_WIDTH(16)) u1 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .din0(din0), .din1(din1), .mode(mode), .acc_clr(acc_clr), .in_last(in_last),
    .out_valid(out_valid1), .out_ready(out_ready), .dout(dout1), .dout_sat(sat1));

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  always @(posedge ap_clk) cyc <= cyc + 1;

  always @(negedge ap_clk)
    if (ap_rst_n && out_valid0 && out_ready)
      obs.push_back('{dout0, sat0, dout1, sat1, cyc});

  function automatic longint wrap40(input longint x);
    longint m;
    m = x & ((longint'(1) << 40) - 1);
    if (m >= (longint'(1) << 39)) m = m - (longint'(1) << 40);
    return m;
  endfunction

  // Q15 result: divide by 2^15 rounding halves upward, then clamp to the output range.
  function automatic void fmt(input longint r, input int dw, output longint v, output logic s);
    longint q, mx;
    q  = (r + 64'sd16384) >>> 15;
    mx = (longint'(1) << (dw - 1)) - 1;
    s  = 1'b1;
    if (q > mx) v = mx;
    else if (q < -mx - 1) v = -mx - 1;
    else begin v = q; s = 1'b0; end
  endfunction

  function automatic void model_accept(input logic [15:0] a, input logic [15:0] b,
                                       input logic m, input logic c, input logic l);
    longint p, res, v32, v16;
    logic   s32, s16;
    bit     emit;
    p    = longint'($signed(a)) * longint'($signed(b));
    emit = 1'b1;
    res  = p;
    if (m) begin
      res = wrap40((c ? 64'sd0 : m_acc) + p);
      if (l) m_acc = 0;
      else begin m_acc = res; emit = 1'b0; end
    end
    if (emit) begin
      fmt(res, 32, v32, s32);
      fmt(res, 16, v16, s16);
      exp_q.push_back('{v32[31:0], s32, v16[15:0], s16});
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic m, input logic c, input logic l);
    int unsigned n = 0;
    in_valid = 1'b1; din0 = a; din1 = b; mode = m; acc_clr = c; in_last = l;
    @(negedge ap_clk);
    while (!in_ready0 && n < 200) begin
      @(negedge ap_clk);
      n++;
    end
    if (!in_ready0) begin
      checks++; failures++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready0);
    end else begin
      last_acc = cyc;
      model_accept(a, b, m, c, l);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
    mode = 1'b0; acc_clr = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    checks++;
    if ({out_valid0, out_valid1, sat0, sat1} !== 4'b0000) begin
      failures++; $display("FAIL reset_flags got=%b required=0000", {out_valid0, out_valid1, sat0, sat1});
    end
    checks++;
    if (dout0 !== 32'h0 || dout1 !== 16'h0) begin
      failures++; $display("FAIL reset_dout got=%h/%h required=0/0", dout0, dout1);
    end
    checks++;
    if ({in_ready0, in_ready1} !== 2'b11) begin
      failures++; $display("FAIL reset_in_ready got=%b required=11", {in_ready0, in_ready1});
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_plain_multiply;
    obs.delete();
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== 1) begin
      failures++; $display("FAIL plain_count got=%0d required=1", obs.size());
    end
    if (obs.size() > 0) begin
      checks++;
      if (obs[0].d32 !== 32'h00002000 || obs[0].s32 !== 1'b0) begin
        failures++; $display("FAIL plain_dout got=%h sat=%b required=00002000 sat=0", obs[0].d32, obs[0].s32);
      end
      checks++;
      if (obs[0].cyc - last_acc !== 3) begin
        failures++; $display("FAIL plain_latency got=%0d required=3", obs[0].cyc - last_acc);
      end
    end
  endtask

  task automatic test_rounding;
    logic [31:0] want [3];
    want = '{32'h1, 32'h0, 32'h0};
    obs.delete();
    send(16'h0001, 16'h4000, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h4000, 1'b0, 1'b0, 1'b0);
    send(16'hFFFF, 16'h2000, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== 3) begin
      failures++; $display("FAIL round_count got=%0d required=3", obs.size());
    end
    for (int i = 0; i < 3 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d32 !== want[i]) begin
        failures++; $display("FAIL round_dout[%0d] got=%h required=%h", i, obs[i].d32, want[i]);
      end
    end
  endtask

  task automatic test_accumulate;
    logic [31:0] want [4];
    int          acc4;
    want = '{32'h8000, 32'h2000, 32'h2000, 32'h4000};
    obs.delete();
    for (int k = 1; k <= 4; k++) send(16'h4000, 16'h4000, 1'b1, k == 1, k == 4);
    acc4 = last_acc;
    send(16'h4000, 16'h4000, 1'b1, 1'b1, 1'b1);
    // mode-0 beat inside an open group must pass through and leave the sum alone
    send(16'h4000, 16'h4000, 1'b1, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 16'h4000, 1'b1, 1'b0, 1'b1);
    repeat (6) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== 4) begin
      failures++; $display("FAIL accum_count got=%0d required=4", obs.size());
    end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      checks++;
      if (obs[i].d32 !== want[i] || obs[i].s32 !== 1'b0) begin
        failures++; $display("FAIL accum_dout[%0d] got=%h sat=%b required=%h sat=0", i, obs[i].d32, obs[i].s32, want[i]);
      end
    end
    if (obs.size() > 0) begin
      checks++;
      if (obs[0].cyc - acc4 !== 3) begin
        failures++; $display("FAIL accum_latency got=%0d required=3", obs[0].cyc - acc4);
      end
      checks++;
      if (obs[0].d16 !== 16'h7FFF || obs[0].s16 !== 1'b1) begin
        failures++; $display("FAIL accum_sat16 got=%h sat=%b required=7fff sat=1", obs[0].d16, obs[0].s16);
      end
    end
  endtask

  task automatic test_saturation;
    obs.delete();
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    send(16'h4000, 16'hC000, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== 2) begin
      failures++; $display("FAIL sat_count got=%0d required=2", obs.size());
    end
    if (obs.size() > 1) begin
      checks++;
      if (obs[0].d16 !== 16'h7FFF || obs[0].s16 !== 1'b1) begin
        failures++; $display("FAIL sat_max16 got=%h sat=%b required=7fff sat=1", obs[0].d16, obs[0].s16);
      end
      checks++;
      if (obs[1].d16 !== 16'hE000 || obs[1].s16 !== 1'b0) begin
        failures++; $display("FAIL sat_neg16 got=%h sat=%b required=e000 sat=0", obs[1].d16, obs[1].s16);
      end
      checks++;
      if (obs[0].d32 !== 32'h00008000 || obs[0].s32 !== 1'b0) begin
        failures++; $display("FAIL sat_max32 got=%h sat=%b required=00008000 sat=0", obs[0].d32, obs[0].s32);
      end
      checks++;
      if (obs[1].d32 !== 32'hFFFFE000) begin
        failures++; $display("FAIL sat_neg32 got=%h required=ffffe000", obs[1].d32);
      end
    end
  endtask

  task automatic test_back_to_back;
    bit stall_seen = 0;
    bit bad = 0;
    obs.delete();
    fork
      begin
        for (int k = 1; k <= 6; k++) send(16'(k), 16'h8000, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (4) @(posedge ap_clk); #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge ap_clk);
          if (in_ready0 === 1'b0) stall_seen = 1;
          if (out_valid0 && in_ready0) bad = 1;
          @(posedge ap_clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    repeat (10) @(posedge ap_clk); #1;
    checks++;
    if (!stall_seen || bad) begin
      failures++; $display("FAIL bp_in_ready stall_seen=%0d held_high=%0d required=1/0", stall_seen, bad);
    end
    checks++;
    if (obs.size() !== 6) begin
      failures++; $display("FAIL bp_count got=%0d required=6", obs.size());
    end
    for (int k = 1; k <= 6 && k <= obs.size(); k++) begin
      checks++;
      if (obs[k-1].d32 !== 32'(-k) || obs[k-1].d16 !== 16'(-k)) begin
        failures++; $display("FAIL bp_dout[%0d] got=%h/%h required=%h/%h", k, obs[k-1].d32, obs[k-1].d16, 32'(-k), 16'(-k));
      end
    end
  endtask

  task automatic test_random;
    bit done = 0;
    int unsigned n = 0;
    obs.delete();
    exp_q.delete();
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) begin @(posedge ap_clk); #1; end
          send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge ap_clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    while (obs.size() < exp_q.size() && n < 100) begin
      @(posedge ap_clk);
      n++;
    end
    repeat (4) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== exp_q.size()) begin
      failures++; $display("FAIL rand_count got=%0d required=%0d", obs.size(), exp_q.size());
    end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs[i].d32 !== exp_q[i].d32 || obs[i].s32 !== exp_q[i].s32 ||
          obs[i].d16 !== exp_q[i].d16 || obs[i].s16 !== exp_q[i].s16) begin
        failures++;
        $display("FAIL rand_out[%0d] got=%h/%b %h/%b required=%h/%b %h/%b", i,
                 obs[i].d32, obs[i].s32, obs[i].d16, obs[i].s16,
                 exp_q[i].d32, exp_q[i].s32, exp_q[i].d16, exp_q[i].s16);
      end
    end
  endtask

  task automatic test_wrap;
    obs.delete();
    for (int i = 0; i < 513; i++) send(16'h8000, 16'h8000, 1'b1, i == 0, i == 512);
    repeat (6) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== 1) begin
      failures++; $display("FAIL wrap_count got=%0d required=1", obs.size());
    end
    if (obs.size() > 0) begin
      checks++;
      if (obs[0].d32 !== 32'hFF008000 || obs[0].s32 !== 1'b0 || obs[0].d16 !== 16'h8000 || obs[0].s16 !== 1'b1) begin
        failures++; $display("FAIL wrap_dout got=%h/%b %h/%b required=ff008000/0 8000/1",
                             obs[0].d32, obs[0].s32, obs[0].d16, obs[0].s16);
      end
    end
  endtask

  task automatic test_reset_mid_group;
    send(16'h4000, 16'h4000, 1'b1, 1'b1, 1'b0);
    send(16'h4000, 16'h4000, 1'b1, 1'b0, 1'b0);
    @(posedge ap_clk); #3;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid0 !== 1'b0 || dout0 !== 32'h0 || dout1 !== 16'h0 || sat1 !== 1'b0) begin
      failures++; $display("FAIL async_reset got=%b/%h/%h/%b required=0/0/0/0", out_valid0, dout0, dout1, sat1);
    end
    m_acc = 0;
    exp_q.delete();
    repeat (2) @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    obs.delete();
    send(16'h4000, 16'h4000, 1'b1, 1'b0, 1'b1);
    repeat (6) @(posedge ap_clk); #1;
    checks++;
    if (obs.size() !== 1) begin
      failures++; $display("FAIL post_reset_count got=%0d required=1", obs.size());
    end
    if (obs.size() > 0) begin
      checks++;
      if (obs[0].d32 !== 32'h00002000) begin
        failures++; $display("FAIL post_reset_dout got=%h required=00002000", obs[0].d32);
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain_multiply();
    test_rounding();
    test_accumulate();
    test_saturation();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid_group();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
